// File: rtl/aline_scheduler_if.sv
// Host, delay-table and transmit-FSM signals of the A-line scheduler.
// master = scheduler side, slave = environment side.
interface aline_scheduler_if #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 16,
    parameter int ALINE_W  = 8,
    parameter int LISTEN_W = 20
);
    logic                      frame_start;
    logic                      abort;
    logic [ALINE_W-1:0]        num_alines;
    logic [LISTEN_W-1:0]       listen_cycles;
    logic [ALINE_W-1:0]        tbl_addr;
    logic                      tbl_rd_en;
    logic [NUM_CH*CNT_W-1:0]   tbl_rd_data;
    logic [NUM_CH*CNT_W-1:0]   delay_bus;
    logic                      input_delay_data;
    logic                      start_transmit;
    logic                      next_aline;
    logic                      transmit_in_progress;
    logic                      transmit_complete;
    logic                      frame_busy;
    logic                      frame_done;
    logic                      tx_timeout;

    modport master (
        input  frame_start, abort, num_alines, listen_cycles,
        input  tbl_rd_data, transmit_in_progress, transmit_complete,
        output tbl_addr, tbl_rd_en, delay_bus,
        output input_delay_data, start_transmit, next_aline,
        output frame_busy, frame_done, tx_timeout
    );

    modport slave (
        output frame_start, abort, num_alines, listen_cycles,
        output tbl_rd_data, transmit_in_progress, transmit_complete,
        input  tbl_addr, tbl_rd_en, delay_bus,
        input  input_delay_data, start_transmit, next_aline,
        input  frame_busy, frame_done, tx_timeout
    );
endinterface

// File: rtl/aline_scheduler.sv
// A-line frame sequencer: table fetch, delay load, fire, wait for
// transmit completion, listen window, advance to the next A-line.
module aline_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 16,
    parameter int ALINE_W  = 8,
    parameter int LISTEN_W = 20,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    aline_scheduler_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_LOAD,
        S_ARM,
        S_FIRE,
        S_WAIT_TX,
        S_LISTEN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ALINE_W-1:0]      r_idx;
    logic [ALINE_W-1:0]      r_num;
    logic [LISTEN_W-1:0]     r_listen;
    logic [LISTEN_W-1:0]     r_lcnt;
    logic [WD_W-1:0]         r_wd;
    logic                    r_sub;
    logic                    r_tc_d;
    logic                    r_tbl_rd_en;
    logic [NUM_CH*CNT_W-1:0] r_delay;
    logic                    r_idd;
    logic                    r_st;
    logic                    r_na;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_to;

    logic w_tc_rise;
    logic w_last;
    logic w_lend;
    logic w_wd_end;

    // Only a fresh edge of the sticky complete level ends WAIT_TX.
    assign w_tc_rise = bus.transmit_complete & ~r_tc_d;
    assign w_last    = (r_idx == r_num - 1'b1);
    assign w_lend    = (r_lcnt == r_listen - 1'b1);
    assign w_wd_end  = (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_num       <= '0;
            r_listen    <= '0;
            r_lcnt      <= '0;
            r_wd        <= '0;
            r_sub       <= 1'b0;
            r_tc_d      <= 1'b0;
            r_tbl_rd_en <= 1'b0;
            r_delay     <= '0;
            r_idd       <= 1'b0;
            r_st        <= 1'b0;
            r_na        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_to        <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= S_IDLE;
            r_sub       <= 1'b0;
            r_tbl_rd_en <= 1'b0;
            r_idd       <= 1'b0;
            r_st        <= 1'b0;
            r_na        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tbl_rd_en <= 1'b0;
            r_na        <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_busy      <= 1'b1;
                        r_to        <= 1'b0;
                        r_idx       <= '0;
                        r_num       <= bus.num_alines;
                        r_listen    <= (bus.listen_cycles == '0) ?
                                       LISTEN_W'(1) : bus.listen_cycles;
                        r_tbl_rd_en <= (bus.num_alines != '0);
                        r_state     <= (bus.num_alines != '0) ?
                                       S_FETCH : S_DONE;
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_delay <= bus.tbl_rd_data;
                    r_idd   <= 1'b1;
                    r_sub   <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sub <= ~r_sub;
                    if (r_sub) begin
                        r_idd   <= 1'b0;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_sub <= ~r_sub;
                    if (r_sub) begin
                        r_st    <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    r_tc_d <= bus.transmit_complete;
                    r_wd   <= r_wd + 1'b1;
                    if (w_wd_end) begin
                        r_st    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_to    <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (bus.transmit_in_progress) begin
                        r_st    <= 1'b0;
                        r_state <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    r_tc_d <= bus.transmit_complete;
                    r_wd   <= r_wd + 1'b1;
                    if (w_tc_rise) begin
                        r_lcnt  <= '0;
                        r_state <= S_LISTEN;
                    end else if (w_wd_end) begin
                        r_busy  <= 1'b0;
                        r_to    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_LISTEN: begin
                    r_lcnt <= r_lcnt + 1'b1;
                    if (w_lend) begin
                        r_na    <= 1'b1;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx       <= r_idx + 1'b1;
                        r_tbl_rd_en <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tbl_addr         = r_idx;
    assign bus.tbl_rd_en        = r_tbl_rd_en;
    assign bus.delay_bus        = r_delay;
    assign bus.input_delay_data = r_idd;
    assign bus.start_transmit   = r_st;
    assign bus.next_aline       = r_na;
    assign bus.frame_busy       = r_busy;
    assign bus.frame_done       = r_done;
    assign bus.tx_timeout       = r_to;
endmodule

// File: tb/tb_aline_scheduler.sv
// Randomized bench for aline_scheduler with delay-table and
// transmit-FSM models plus a frame-level scoreboard.
module tb_aline_scheduler;
    localparam int NUM_CH   = 8;
    localparam int CNT_W    = 16;
    localparam int ALINE_W  = 8;
    localparam int LISTEN_W = 20;
    localparam int TIMEOUT  = 100;
    localparam int DW       = NUM_CH * CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aline_scheduler_if #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W),
        .ALINE_W(ALINE_W), .LISTEN_W(LISTEN_W)
    ) bus ();

    aline_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ALINE_W(ALINE_W),
        .LISTEN_W(LISTEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] tbl [8];
    int tx_mode = 3;

    int fs_cyc = 0, ld_idx = 0, exp_l = 1;
    int ld_tot = 0, na_tot = 0, fd_tot = 0, st_tot = 0, rise_tot = 0;
    int idd_len = 0, st_cyc = 0, rise_cyc = 0;
    logic p_idd = 0, p_st = 0, p_na = 0, p_to = 0;
    logic rd_pend = 0;
    logic [ALINE_W-1:0] rd_addr = '0;
    int tx_act = 0, started = 0, ip_wait = 0, hold = 0, busy_c = 0;

    always @(negedge clk) begin
        if (rst && bus.frame_start && !bus.abort && !bus.frame_busy) begin
            fs_cyc = cyc;
            ld_idx = 0;
            exp_l  = (bus.listen_cycles == 0) ? 1 : int'(bus.listen_cycles);
        end
        if (bus.tbl_rd_en)
            chk("tbl_addr", bus.tbl_addr, ld_idx);
        if (bus.input_delay_data && !p_idd) begin
            chk("load_data", bus.delay_bus, tbl[ld_idx]);
            ld_idx++;
            ld_tot++;
            idd_len = 0;
        end
        if (bus.input_delay_data) idd_len++;
        if (!bus.input_delay_data && p_idd)
            chk("load_len", idd_len, 2);
        if (bus.start_transmit && !p_st) begin
            st_cyc = cyc;
            st_tot++;
            if (ld_idx == 1) chk("fire_latency", cyc - fs_cyc, 7);
        end
        if (bus.next_aline) begin
            na_tot++;
            if (!p_na) chk("listen_len", cyc - rise_cyc, exp_l + 1);
        end
        if (bus.frame_done) fd_tot++;
        if (bus.tx_timeout && !p_to)
            chk("timeout_lat", cyc - st_cyc, TIMEOUT);
        p_idd = bus.input_delay_data;
        p_st  = bus.start_transmit;
        p_na  = bus.next_aline;
        p_to  = bus.tx_timeout;

        // delay table: data valid in the cycle after the read strobe
        if (rd_pend) bus.tbl_rd_data = tbl[rd_addr];
        else bus.tbl_rd_data = {$urandom, $urandom, $urandom, $urandom};
        rd_pend = bus.tbl_rd_en;
        rd_addr = bus.tbl_addr;

        if (tx_mode == 3) begin
            bus.transmit_in_progress = 1'b0;
            bus.transmit_complete    = 1'b0;
            tx_act = 0;
            started = 0;
        end else if (bus.start_transmit && tx_act == 0) begin
            tx_act  = 1;
            started = 0;
            ip_wait = $urandom_range(0, 2);
        end else if (tx_act == 1 && started == 0) begin
            if (ip_wait == 0) begin
                started = 1;
                bus.transmit_in_progress = 1'b1;
                hold   = (tx_mode == 1) ? $urandom_range(2, 5) : 0;
                busy_c = hold + $urandom_range(2, 6);
                if (hold == 0) bus.transmit_complete = 1'b0;
            end else begin
                ip_wait--;
            end
        end else if (started == 1 && tx_mode != 2) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) bus.transmit_complete = 1'b0;
            end
            busy_c--;
            if (busy_c <= 0) begin
                bus.transmit_in_progress = 1'b0;
                bus.transmit_complete    = 1'b1;
                rise_cyc = cyc;
                rise_tot++;
                tx_act  = 0;
                started = 0;
            end
        end
    end

    task automatic fill_tbl(input bit rnd);
        for (int k = 0; k < 8; k++)
            tbl[k] = rnd ? {$urandom, $urandom, $urandom, $urandom}
                         : {NUM_CH{CNT_W'(k + 1)}};
    endtask

    task automatic pulse_start(input int n, input int l);
        bus.num_alines    = ALINE_W'(n);
        bus.listen_cycles = LISTEN_W'(l);
        bus.frame_start   = 1'b1;
        tick();
        bus.frame_start   = 1'b0;
    endtask

    task automatic run_frame(input int n, input int l, input int mode,
                             input bit rnd, input bit dup);
        int ld0, na0, fd0, st0;
        bit tmo;
        tmo = (mode == 2);
        tx_mode = 3;
        tick();
        tx_mode = mode;
        fill_tbl(rnd);
        ld0 = ld_tot; na0 = na_tot; fd0 = fd_tot; st0 = st_tot;
        pulse_start(n, l);
        chk("busy_on", bus.frame_busy, 1);
        chk("to_clear", bus.tx_timeout, 0);
        if (n == 0) begin
            tick();
            chk("zero_done", {bus.frame_done, bus.frame_busy}, 2'b10);
        end
        if (dup) begin
            repeat (3) tick();
            pulse_start(5, 0);
        end
        for (int i = 0; i < 3000; i++) begin
            if (fd_tot != fd0 || bus.tx_timeout) break;
            tick();
        end
        repeat (2) tick();
        chk("loads", ld_tot - ld0, tmo ? 1 : n);
        chk("fires", st_tot - st0, tmo ? 1 : n);
        chk("next_alines", na_tot - na0, tmo ? 0 : n);
        chk("frame_dones", fd_tot - fd0, tmo ? 0 : 1);
        chk("tx_timeout", bus.tx_timeout, tmo);
        chk("busy_off", bus.frame_busy, 0);
    endtask

    initial begin
        bus.frame_start   = 1'b0;
        bus.abort         = 1'b0;
        bus.num_alines    = '0;
        bus.listen_cycles = '0;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_outs", {bus.tbl_rd_en, bus.input_delay_data,
            bus.start_transmit, bus.next_aline, bus.frame_busy,
            bus.frame_done, bus.tx_timeout, bus.tbl_addr}, 0);
        chk("rst_delay", bus.delay_bus, 0);
        rst = 1'b1;
        tick();

        run_frame(3, 10, 0, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++)
            run_frame($urandom_range(1, 4), $urandom_range(0, 6),
                      $urandom_range(0, 1), 1'b1, 1'b0);
        run_frame(3, 3, 1, 1'b1, 1'b0);
        run_frame(0, 4, 0, 1'b1, 1'b0);
        run_frame(2, 5, 2, 1'b1, 1'b0);
        run_frame(2, 2, 0, 1'b1, 1'b0);

        begin : abort_test
            int r0, fd0, na0;
            tx_mode = 3;
            tick();
            tx_mode = 0;
            fill_tbl(1'b1);
            r0 = rise_tot; fd0 = fd_tot; na0 = na_tot;
            pulse_start(3, 10);
            for (int i = 0; i < 500 && rise_tot < r0 + 2; i++) tick();
            chk("abort_wait", rise_tot - r0, 2);
            tick();
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            chk("abort_outs", {bus.tbl_rd_en, bus.input_delay_data,
                bus.start_transmit, bus.next_aline, bus.frame_busy,
                bus.frame_done}, 0);
            chk("abort_delay", bus.delay_bus, tbl[1]);
            repeat (15) tick();
            chk("abort_done", fd_tot - fd0, 0);
            chk("abort_na", na_tot - na0, 1);
        end

        begin : reset_test
            bit in_wait;
            tx_mode = 3;
            tick();
            tx_mode = 2;
            fill_tbl(1'b1);
            pulse_start(2, 3);
            in_wait = 0;
            for (int i = 0; i < 50 && !in_wait; i++) begin
                tick();
                in_wait = bus.transmit_in_progress && !bus.start_transmit;
            end
            chk("wait_tx_reached", in_wait, 1);
            repeat (3) tick();
            rst = 1'b0;
            tick();
            rst = 1'b1;
            chk("mid_rst_outs", {bus.tbl_rd_en, bus.input_delay_data,
                bus.start_transmit, bus.next_aline, bus.frame_busy,
                bus.frame_done, bus.tx_timeout, bus.tbl_addr}, 0);
            chk("mid_rst_delay", bus.delay_bus, 0);
        end

        run_frame(2, 2, 0, 1'b1, 1'b1);

        begin : start_abort_test
            int fd0, ld0;
            fd0 = fd_tot; ld0 = ld_tot;
            bus.abort = 1'b1;
            pulse_start(2, 1);
            bus.abort = 1'b0;
            chk("sa_busy", bus.frame_busy, 0);
            repeat (12) tick();
            chk("sa_loads", ld_tot - ld0, 0);
            chk("sa_done", fd_tot - fd0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end
endmodule
